// File: rtl/fp_seq_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_seq_write_buffer_if
// Description : Request side (sequence generator) and SRAM write port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_seq_write_buffer_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_ready;
    logic        sram_req;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_gnt;

    modport master (
        output mem_addr, mem_wdata, mem_write, sram_gnt,
        input  mem_ready, sram_req, sram_addr, sram_wdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_write, sram_gnt,
        output mem_ready, sram_req, sram_addr, sram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/fp_seq_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fp_seq_write_buffer
// Description : Word write buffer between a sequence generator and an SRAM
//               port, with a one-entry overflow slot and status counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_seq_write_buffer #(
    parameter int DEPTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    fp_seq_write_buffer_if.slave    bus,
    input  wire logic               clr_status,
    output logic [15:0]             wr_count,
    output logic                    err_misalign,
    output logic                    err_overflow,
    output logic                    idle
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_REQ  = 1'b1
    } drain_t;

    logic [29:0]        r_fifo_addr [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_pend_vld;
    logic [29:0]        r_pend_addr;
    logic [31:0]        r_pend_data;
    logic               r_mem_ready;
    drain_t             r_state;
    logic               r_sram_req;
    logic [29:0]        r_sram_addr;
    logic [31:0]        r_sram_wdata;
    logic [15:0]        r_wr_count;
    logic               r_err_misalign;
    logic               r_err_overflow;

    logic               w_full;
    logic               w_overflow;
    logic               w_misalign;
    logic               w_new_ok;
    logic               w_push_new;
    logic               w_capture;
    logic               w_push_pend;
    logic               w_push;
    logic [29:0]        w_push_addr;
    logic [31:0]        w_push_data;
    logic               w_ack;
    logic               w_pop;
    logic [c_PTR_W-1:0] w_next_rd;

    // Fullness is judged on the pre-edge count, so a same-edge pop never
    // makes room for the pending slot or a new request.
    assign w_full      = (r_count == c_DEPTH);
    assign w_overflow  = bus.mem_write && r_pend_vld;
    assign w_misalign  = bus.mem_write && !r_pend_vld && (bus.mem_addr[1:0] != 2'b00);
    assign w_new_ok    = bus.mem_write && !r_pend_vld && (bus.mem_addr[1:0] == 2'b00);
    assign w_push_new  = w_new_ok && !w_full;
    assign w_capture   = w_new_ok && w_full;
    assign w_push_pend = r_pend_vld && !w_full;
    assign w_push      = w_push_new || w_push_pend;
    assign w_push_addr = r_pend_vld ? r_pend_addr : bus.mem_addr[31:2];
    assign w_push_data = r_pend_vld ? r_pend_data : bus.mem_wdata;
    assign w_ack       = w_push || w_misalign;
    assign w_pop       = (r_state == D_REQ) && bus.sram_gnt;
    assign w_next_rd   = r_rd_ptr + c_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_push_addr;
            r_fifo_data[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_mem_ready <= 1'b0;
        end else begin
            r_mem_ready <= w_ack;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_next_rd;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (w_capture) begin
                r_pend_vld  <= 1'b1;
                r_pend_addr <= bus.mem_addr[31:2];
                r_pend_data <= bus.mem_wdata;
            end else if (w_push_pend) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    // The head stays in the FIFO until granted; on grant the next entry is
    // presented immediately when one is already stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= D_IDLE;
            r_sram_req   <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            case (r_state)
                D_IDLE: begin
                    if (r_count != '0) begin
                        r_sram_addr  <= r_fifo_addr[r_rd_ptr];
                        r_sram_wdata <= r_fifo_data[r_rd_ptr];
                        r_sram_req   <= 1'b1;
                        r_state      <= D_REQ;
                    end
                end
                D_REQ: begin
                    if (bus.sram_gnt) begin
                        if (r_count > c_CNT_W'(1)) begin
                            r_sram_addr  <= r_fifo_addr[w_next_rd];
                            r_sram_wdata <= r_fifo_data[w_next_rd];
                        end else begin
                            r_sram_req <= 1'b0;
                            r_state    <= D_IDLE;
                        end
                    end
                end
                default: begin
                    r_sram_req <= 1'b0;
                    r_state    <= D_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_count     <= '0;
            r_err_misalign <= 1'b0;
            r_err_overflow <= 1'b0;
        end else if (clr_status) begin
            r_wr_count     <= '0;
            r_err_misalign <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_pop && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_misalign) begin
                r_err_misalign <= 1'b1;
            end
            if (w_overflow) begin
                r_err_overflow <= 1'b1;
            end
        end
    end

    assign bus.mem_ready  = r_mem_ready;
    assign bus.sram_req   = r_sram_req;
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;
    assign wr_count       = r_wr_count;
    assign err_misalign   = r_err_misalign;
    assign err_overflow   = r_err_overflow;
    assign idle           = (r_count == '0) && !r_pend_vld && (r_state == D_IDLE) && !r_mem_ready;
endmodule
`default_nettype wire

// File: doc/fp_seq_write_buffer.md
FP_SEQ_WRITE_BUFFER -- requirements
Module: fp_seq_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_addr  input  32  byte address of write request from sequence generator.
REQ-005 mem_wdata  input  32  IEEE-754 word to store.
REQ-006 mem_write  input  1  one-cycle request pulse; addr/wdata valid in that cycle only.
REQ-007 mem_ready  output  1  one-cycle acknowledge per accepted request.
REQ-008 sram_req  output  1  write request to SRAM port.
REQ-009 sram_addr  output  30  word address (mem_addr[31:2]).
REQ-010 sram_wdata  output  32  data to SRAM.
REQ-011 sram_gnt  input  1  SRAM accepted current request this cycle.
REQ-012 clr_status  input  1  synchronous clear of wr_count and error flags.
REQ-013 wr_count  output  16  words committed to SRAM, saturating.
REQ-014 err_misalign  output  1  sticky: request with mem_addr[1:0] != 0 seen.
REQ-015 err_overflow  output  1  sticky: request arrived while pending slot occupied.
REQ-016 idle  output  1  FIFO empty, no pending request, drain FSM in IDLE, mem_ready low.

Function
REQ-017 Accept path SHALL, on edge sampling mem_write=1 with FIFO not full and pending slot empty, push {addr[31:2], wdata} and drive mem_ready=1 for the following cycle only.
REQ-018 If FIFO full at that edge, request SHALL be captured into a single pending slot; mem_ready SHALL stay 0.
REQ-019 Pending slot SHALL push on first edge where FIFO count (before that edge's pop) < DEPTH; mem_ready=1 the following cycle; a same-edge pop does not free space for the pending push.
REQ-020 mem_write=1 while pending slot occupied SHALL set err_overflow and drop the new request, no mem_ready for it.
REQ-021 Misaligned request SHALL not be pushed, SHALL set err_misalign, and SHALL still receive mem_ready exactly as an aligned request accepted that edge.
REQ-022 Drain FSM states: D_IDLE, D_REQ.
REQ-023 D_IDLE: if FIFO non-empty, load head into sram_addr/sram_wdata, sram_req=1, go D_REQ; sram_gnt ignored in D_IDLE.
REQ-024 D_REQ: sram_req, sram_addr, sram_wdata SHALL hold stable until sram_gnt=1 sampled.
REQ-025 On grant: pop head, increment wr_count (saturate at 16'hFFFF); if another entry remains, load it and stay D_REQ with sram_req held 1 (back-to-back); else sram_req=0, go D_IDLE.
REQ-026 Push and pop on same edge SHALL both take effect; count unchanged; order preserved (strict FIFO, no reordering).
REQ-027 Push into empty FIFO: sram_req SHALL assert no earlier than the cycle after the push edge.
REQ-028 clr_status=1 SHALL zero wr_count, err_misalign, err_overflow at that edge; clear wins over simultaneous increment or error set.
REQ-029 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-030 rst_n low SHALL immediately force: mem_ready=0, sram_req=0, sram_addr=0, sram_wdata=0, wr_count=0, err_misalign=0, err_overflow=0, idle=1, FIFO empty, pending empty, FSM D_IDLE.
REQ-031 Reset mid-transfer SHALL discard all buffered and pending data; no SRAM write completes after reset assertion.

Verification
REQ-032 Single write: mem_write pulse addr=0x100, wdata=0x3F800000, sram_gnt tied 1 -> mem_ready pulse next cycle; sram_req with sram_addr=0x40, sram_wdata=0x3F800000; wr_count=1; idle=1 after.
REQ-033 Backpressure: sram_gnt=0, 5 requests at addr 0x0,0x4,...,0x10 spaced by mem_ready -> first 4 acked, 5th pending no ack; release gnt -> 5th acked one cycle after first pop+1; SRAM sees 0x0..0x4 in order, wr_count=5.
REQ-034 Overflow: FIFO full, pending occupied, extra mem_write -> err_overflow=1, request dropped, wr_count final excludes it.
REQ-035 Misaligned: addr=0x102 -> mem_ready pulse, err_misalign=1, no sram_req, wr_count unchanged.
REQ-036 Back-to-back drain: 3 entries queued, sram_gnt=1 continuously -> sram_req high 3 consecutive cycles, addresses incrementing by 1.
REQ-037 Reset mid-operation: 2 entries queued, gnt=0, assert rst_n low -> all outputs reset values; after release no sram_req until new mem_write.
